pipeline_stage_buffer: RTL

PIPELINE_STAGE_BUFFER -- requirements
Module: pipeline_stage_buffer

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/pipeline_stage_buffer_if.sv | 14 +
 rtl/pipeline_stage_buffer_sat_counter.sv | 25 ++
 rtl/pipeline_stage_buffer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for all inter-stage pipeline buffers: control-bundle
// layout and the NOP bubble presented by an empty stage.
package pipeline_pkg;

  localparam int CTRL_EX_W   = 5;
  localparam int CTRL_MEM_W  = 3;
  localparam int CTRL_WB_W   = 3;
  localparam int CTRL_EX_OFF  = 0;
  localparam int CTRL_MEM_OFF = CTRL_EX_OFF + CTRL_EX_W;
  localparam int CTRL_WB_OFF  = CTRL_MEM_OFF + CTRL_MEM_W;
  localparam int CTRL_NB_DEF  = CTRL_WB_OFF + CTRL_WB_W;

  localparam logic [CTRL_NB_DEF-1:0] CTRL_BUBBLE_DEF = 11'b000_0010_0000;

endpackage

// File: rtl/pipeline_stage_buffer_if.sv
// Valid/ready beat bus between pipeline stages; the producer is the master.
interface pipeline_stage_buffer_if #(
  parameter int NB_DATA = 32,
  parameter int NB_CTRL = 11
);
  logic               valid;
  logic               ready;
  logic [NB_DATA-1:0] data;
  logic [NB_CTRL-1:0] ctrl;
  logic               halt;

  modport master (output valid, data, ctrl, halt, input ready);
  modport slave  (input valid, data, ctrl, halt, output ready);
endinterface

// File: rtl/pipeline_stage_buffer_sat_counter.sv
// Saturating up-counter, falling-edge clocked, cleared by async reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(negedge clock or posedge reset_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stage_buffer.sv
// Inter-stage pipeline buffer with flush, halt lock and stall counter.
// Define PIPELINE_SKID_BUFFER_EN to add a skid entry and register ready.
module pipeline_stage_buffer
  import pipeline_pkg::*;
#(
  parameter int                 NB_DATA     = 32,
  parameter int                 NB_CTRL     = CTRL_NB_DEF,
  parameter logic [NB_CTRL-1:0] CTRL_BUBBLE = CTRL_BUBBLE_DEF,
  parameter int                 NB_CNT      = 16
) (
  input  logic                    clock,
  input  logic                    reset_i,
  input  logic                    flush_i,
  pipeline_stage_buffer_if.slave  up,
  pipeline_stage_buffer_if.master dn,
  output logic [NB_CNT-1:0]       stall_count_o
);

  logic               m_vld_q, m_vld_d;
  logic [NB_DATA-1:0] m_data_q, m_data_d;
  logic [NB_CTRL-1:0] m_ctrl_q, m_ctrl_d;
  logic               m_halt_q, m_halt_d;
  logic               halt_lock_q, halt_lock_d;
  logic               ready;
  logic               in_fire;
  logic               out_fire;
  logic               stall_inc;
`ifdef PIPELINE_SKID_BUFFER_EN
  logic               s_vld_q, s_vld_d;
  logic [NB_DATA-1:0] s_data_q, s_data_d;
  logic [NB_CTRL-1:0] s_ctrl_q, s_ctrl_d;
  logic               s_halt_q, s_halt_d;
`endif

  always_comb begin
`ifdef PIPELINE_SKID_BUFFER_EN
    ready    = !s_vld_q && !halt_lock_q;
    s_vld_d  = s_vld_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    s_halt_d = s_halt_q;
`else
    ready    = (dn.ready || !m_vld_q) && !halt_lock_q;
`endif
    in_fire     = up.valid && ready && !flush_i;
    out_fire    = m_vld_q && dn.ready;
    stall_inc   = m_vld_q && !dn.ready && !flush_i;
    halt_lock_d = halt_lock_q || (in_fire && up.halt);
    m_vld_d     = m_vld_q;
    m_data_d    = m_data_q;
    m_ctrl_d    = m_ctrl_q;
    m_halt_d    = m_halt_q;
    // Flush drops everything held and whatever is offered this cycle.
    if (flush_i) begin
      m_vld_d = 1'b0;
`ifdef PIPELINE_SKID_BUFFER_EN
      s_vld_d = 1'b0;
`endif
    end else begin
`ifdef PIPELINE_SKID_BUFFER_EN
      if (!m_vld_q || out_fire) begin
        if (s_vld_q) begin
          m_vld_d  = 1'b1;
          m_data_d = s_data_q;
          m_ctrl_d = s_ctrl_q;
          m_halt_d = s_halt_q;
          s_vld_d  = 1'b0;
        end else begin
          m_vld_d  = in_fire;
          m_data_d = up.data;
          m_ctrl_d = up.ctrl;
          m_halt_d = up.halt;
        end
      end else if (in_fire) begin
        s_vld_d  = 1'b1;
        s_data_d = up.data;
        s_ctrl_d = up.ctrl;
        s_halt_d = up.halt;
      end
`else
      if (in_fire) begin
        m_vld_d  = 1'b1;
        m_data_d = up.data;
        m_ctrl_d = up.ctrl;
        m_halt_d = up.halt;
      end else if (out_fire) begin
        m_vld_d = 1'b0;
      end
`endif
    end
  end

  // Control state: async reset empties the stage and releases the halt lock.
  always_ff @(negedge clock or posedge reset_i) begin
    if (reset_i) begin
      m_vld_q     <= 1'b0;
      halt_lock_q <= 1'b0;
`ifdef PIPELINE_SKID_BUFFER_EN
      s_vld_q     <= 1'b0;
`endif
    end else begin
      m_vld_q     <= m_vld_d;
      halt_lock_q <= halt_lock_d;
`ifdef PIPELINE_SKID_BUFFER_EN
      s_vld_q     <= s_vld_d;
`endif
    end
  end

  // Payload: no reset needed, outputs are masked while the entry is empty.
  always_ff @(negedge clock) begin
    m_data_q <= m_data_d;
    m_ctrl_q <= m_ctrl_d;
    m_halt_q <= m_halt_d;
`ifdef PIPELINE_SKID_BUFFER_EN
    s_data_q <= s_data_d;
    s_ctrl_q <= s_ctrl_d;
    s_halt_q <= s_halt_d;
`endif
  end

  sat_counter #(.WIDTH(NB_CNT)) u_stall_cnt (
    .clock   (clock),
    .reset_i (reset_i),
    .inc_i   (stall_inc),
    .count_o (stall_count_o)
  );

  assign up.ready = ready;
  assign dn.valid = m_vld_q;
  assign dn.data  = m_vld_q ? m_data_q : '0;
  assign dn.ctrl  = m_vld_q ? m_ctrl_q : CTRL_BUBBLE;
  assign dn.halt  = m_vld_q && m_halt_q;

endmodule
